// File: rtl/uart_pkt_parser.sv
// Framing stage behind a UART receiver: parses HEADER/LEN/payload/CSUM frames,
// buffers the payload and replays checksum-clean frames on a valid/ready byte stream.
module uart_pkt_parser #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned TIMEOUT_BYTES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_flag,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       drop,
  output logic       busy
);

  localparam int unsigned TIMEOUT_CYC = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
  localparam int unsigned GAP_W       = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ok_q, ok_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             drop_q, drop_d;
  logic             buf_we;
  logic             last;
  logic             in_field;
  logic [7:0]       buf_q [MAX_LEN];

  assign last     = (state_q == S_DRAIN) && (8'(rd_idx_q) == len_q - 8'd1);
  assign in_field = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    sum_d    = sum_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    gap_d    = gap_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    drop_d   = 1'b0;
    buf_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (in_flag && in_data == HEADER) state_d = S_LEN;
      end
      S_LEN: begin
        if (in_flag) begin
          if (in_data == 8'd0 || in_data > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = S_IDLE;
          end else begin
            len_d    = in_data;
            sum_d    = in_data;
            wr_idx_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (in_flag) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + in_data;
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (8'(wr_idx_q) == len_q - 8'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (in_flag) begin
          if (in_data == sum_q) begin
            ok_d     = 1'b1;
            rd_idx_d = '0;
            state_d  = S_DRAIN;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd2;
            state_d = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (in_flag) drop_d = 1'b1;
        if (out_ready) begin
          if (last) state_d = S_IDLE;
          else      rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Gap timer shared by all field states; a byte in the expiry cycle wins.
    if (in_field) begin
      if (in_flag) begin
        gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
        err_d   = 1'b1;
        code_d  = 2'd3;
        state_d = S_IDLE;
      end else begin
        gap_d = gap_q + GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      sum_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      gap_q    <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      gap_q    <= gap_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_idx_q] <= in_data;
  end

  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = out_valid ? buf_q[rd_idx_q] : '0;
  assign out_last  = last;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = code_q;
  assign drop      = drop_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Bench for uart_pkt_parser: directed frames plus randomized frames and backpressure,
// checked against a frame-level reference model.
module tb_uart_pkt_parser;

  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned MAX_LEN   = 16;
  localparam logic [7:0]  HDR       = 8'hA5;
  localparam int          TO        = 3 * 10 * (CLK_FREQ / BAUD_RATE);

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_flag;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       drop;
  logic       busy;

  uart_pkt_parser #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .MAX_LEN(MAX_LEN),
    .HEADER(HDR),
    .TIMEOUT_BYTES(3)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_flag(in_flag),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observation log, written only here.
  int         ok_cnt = 0;
  int         drop_cnt = 0;
  int         stab_bad = 0;
  int         vok_bad = 0;
  logic [1:0] err_log[$];
  logic [8:0] out_log[$];
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [8:0] prev_word = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (frame_ok) ok_cnt++;
      if (frame_err) err_log.push_back(err_code);
      if (drop) drop_cnt++;
      if (out_valid && !prev_valid && !frame_ok) vok_bad++;
      if (prev_stall && (!out_valid || {out_last, out_data} != prev_word)) stab_bad++;
      if (out_valid && out_ready) out_log.push_back({out_last, out_data});
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_word  = {out_last, out_data};
    end
  end

  int         tests = 0;
  int         fails = 0;
  int         exp_ok;
  int         exp_code;
  int         exp_drops = 0;
  logic [8:0] exp_out[$];
  int         ok_base, err_base, out_base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decide the frame outcome directly from the framing rules.
  task automatic prep_frame(input bq_t fr);
    int         len;
    logic [7:0] s;
    exp_out.delete();
    exp_ok   = 0;
    exp_code = 0;
    len      = int'(fr[0]);
    if (len == 0 || len > int'(MAX_LEN)) begin
      exp_code = 1;
    end else begin
      s = 8'd0;
      for (int i = 0; i <= len; i++) s = s + fr[i];
      if (fr[len + 1] == s) begin
        exp_ok = 1;
        for (int i = 1; i <= len; i++) exp_out.push_back({(i == len), fr[i]});
      end else begin
        exp_code = 2;
      end
    end
    ok_base  = ok_cnt;
    err_base = err_log.size();
    out_base = out_log.size();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_flag = 1'b1;
    in_data = b;
    @(posedge clk); #1;
    in_flag = 1'b0;
  endtask

  task automatic send_frame(input bq_t fr, input int max_gap);
    send_byte(HDR);
    foreach (fr[i]) begin
      if (max_gap > 0) idle($urandom_range(max_gap));
      send_byte(fr[i]);
    end
  endtask

  task automatic finish_frame(input int pct, output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 500) begin
      out_ready = ($urandom_range(99) < pct);
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_bound", {31'd0, busy}, 0);
    out_ready = 1'b1;
    idle(2);
    check("ok_count", ok_cnt - ok_base, exp_ok);
    check("err_count", err_log.size() - err_base, (exp_code != 0) ? 1 : 0);
    if (exp_code != 0 && err_log.size() > err_base)
      check("err_code", {30'd0, err_log[err_base]}, exp_code);
    check("out_count", out_log.size() - out_base, exp_out.size());
    for (int i = 0; i < exp_out.size(); i++)
      if (out_base + i < out_log.size())
        check($sformatf("out_byte%0d", i), {23'd0, out_log[out_base + i]}, {23'd0, exp_out[i]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t        fr;
    int         cyc;
    int         quiet;
    int         ob, eb;
    int         kind, len, pct;
    logic [7:0] s, b;

    rst = 1'b1; in_flag = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, drop, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // 1: good frame, full throughput
    fr = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    prep_frame(fr); send_frame(fr, 0); finish_frame(100, cyc);
    check("throughput_cycles", cyc, 3);

    // 2: checksum mismatch, then a clean frame
    fr = '{8'h02, 8'h10, 8'h20, 8'h00};
    prep_frame(fr); send_frame(fr, 0); finish_frame(100, cyc);
    fr = '{8'h02, 8'h10, 8'h20, 8'h32};
    prep_frame(fr); send_frame(fr, 1); finish_frame(100, cyc);

    // 3: bad lengths, then a one-byte frame
    fr = '{8'h00};
    prep_frame(fr); send_frame(fr, 0); finish_frame(100, cyc);
    fr = '{8'h11};
    prep_frame(fr); send_frame(fr, 0); finish_frame(100, cyc);
    fr = '{8'h01, 8'h7E, 8'h7F};
    prep_frame(fr); send_frame(fr, 0); finish_frame(100, cyc);

    // 4: timeout fires exactly TO cycles after the last byte
    send_byte(HDR); send_byte(8'h02); send_byte(8'h10);
    quiet = 1;
    repeat (TO) begin
      @(negedge clk);
      if (frame_err !== 1'b0 || busy !== 1'b1) quiet = 0;
    end
    check("timeout_quiet", quiet, 1);
    @(negedge clk);
    check("timeout_err", {31'd0, frame_err}, 1);
    check("timeout_code", {30'd0, err_code}, 3);
    @(negedge clk);
    check("timeout_idle", {31'd0, busy}, 0);
    @(posedge clk); #1;

    // 4b: a byte landing on the expiry cycle is accepted
    fr = '{8'h02, 8'h10, 8'h20, 8'h32};
    prep_frame(fr);
    send_byte(HDR); send_byte(8'h02); send_byte(8'h10);
    idle(TO - 1);
    send_byte(8'h20); send_byte(8'h32);
    finish_frame(100, cyc);

    // 5: stalled output, byte dropped during drain, then random backpressure
    fr = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    prep_frame(fr);
    out_ready = 1'b0;
    send_frame(fr, 0);
    @(negedge clk);
    check("drain_first_valid", {31'd0, out_valid}, 1);
    check("drain_first_ok", {31'd0, frame_ok}, 1);
    check("drain_first_data", {24'd0, out_data}, 32'h11);
    @(posedge clk); #1;
    send_byte(HDR);
    exp_drops++;
    @(negedge clk);
    check("drop_pulse", {31'd0, drop}, 1);
    check("drop_data_held", {23'd0, out_last, out_data}, 32'h011);
    @(posedge clk); #1;
    finish_frame(50, cyc);

    // 6: noise before header, then reset mid-payload
    fr = '{8'h02, 8'hA5, 8'h5A, 8'h01};
    prep_frame(fr);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    send_frame(fr, 0);
    finish_frame(100, cyc);
    ob = ok_cnt; eb = err_log.size();
    send_byte(HDR); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {out_data, out_valid, out_last, frame_ok, frame_err, err_code, drop, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    check("midreset_no_ok", ok_cnt - ob, 0);
    check("midreset_no_err", err_log.size() - eb, 0);
    fr = '{8'h01, 8'h7E, 8'h7F};
    prep_frame(fr); send_frame(fr, 0); finish_frame(100, cyc);

    // Randomized frames: good, bad checksum, bad length; random gaps and readiness
    for (int n = 0; n < 40; n++) begin
      fr.delete();
      kind = $urandom_range(3);
      if (kind == 1) begin
        len = ($urandom_range(1) == 0) ? 0 : $urandom_range(255, 17);
        fr.push_back(8'(len));
      end else begin
        len = $urandom_range(MAX_LEN, 1);
        fr.push_back(8'(len));
        s = 8'(len);
        repeat (len) begin
          b = 8'($urandom);
          fr.push_back(b);
          s = s + b;
        end
        if (kind == 0) s = s ^ 8'($urandom_range(255, 1));
        fr.push_back(s);
      end
      case ($urandom_range(2))
        0:       pct = 100;
        1:       pct = 50;
        default: pct = 25;
      endcase
      prep_frame(fr);
      send_frame(fr, 3);
      finish_frame(pct, cyc);
    end

    check("stall_stability", stab_bad, 0);
    check("valid_with_ok", vok_bad, 0);
    check("drop_total", drop_cnt, exp_drops);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
